// File: rtl/gsim_row_prefetch.sv
// gsim_row_prefetch: burst row-read front-end for the GSIM solver.
// Issues a credit-limited burst of row reads and returns rows in address
// order through a small FIFO on a valid/ready handshake.
// Optional feature macro: GSIM_ROW_FWD_EN (forward a return straight to the
// output when the FIFO is empty).
module gsim_row_prefetch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 256
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [AW-1:0] i_base_addr,
  input  logic [4:0]    i_len,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_mem_rreq,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_rrdy,
  input  logic [DW-1:0] i_mem_dout,
  input  logic          i_mem_dout_vld,
  output logic          o_row_vld,
  output logic [DW-1:0] o_row_data,
  output logic [4:0]    o_row_idx,
  output logic          o_row_last,
  input  logic          i_row_rdy
);

  localparam int unsigned LW = 5;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q;
  logic [LW-1:0]   len_q, issued_q, ret_q;
  logic [CW-1:0]   occ_q, outst_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            done_q, err_q;

  logic [DW-1:0]   mem_data_q [DEPTH];
  logic [LW-1:0]   mem_idx_q  [DEPTH];
  logic [DEPTH-1:0] mem_last_q;

  logic start_burst, zero_start, last_pop;
  logic active, credit_ok, accept;
  logic ret_ok, ret_bad, ret_last;
  logic fifo_vld, fwd, pop, fifo_pop, fifo_wr;

  // Request side: decoded from registers only, no input feeds o_mem_rreq.
  assign active     = (state_q != S_IDLE);
  assign credit_ok  = (occ_q + outst_q) < CW'(DEPTH);
  assign o_mem_rreq = (state_q == S_FETCH) && (issued_q < len_q) && credit_ok;
  assign o_mem_addr = base_q + AW'(issued_q);
  assign accept     = o_mem_rreq & i_mem_rrdy;

  // Return side: a strobe with nothing outstanding is a protocol error.
  assign ret_ok   = i_mem_dout_vld && active && (outst_q != '0);
  assign ret_bad  = i_mem_dout_vld && !ret_ok;
  assign ret_last = (ret_q == (len_q - LW'(1)));
  assign fifo_vld = (occ_q != '0);

`ifdef GSIM_ROW_FWD_EN
  assign fwd        = ret_ok & ~fifo_vld;
  assign o_row_data = fwd ? i_mem_dout : mem_data_q[rd_ptr_q];
  assign o_row_idx  = fwd ? ret_q      : mem_idx_q[rd_ptr_q];
  assign o_row_last = fwd ? ret_last   : mem_last_q[rd_ptr_q];
`else
  assign fwd        = 1'b0;
  assign o_row_data = mem_data_q[rd_ptr_q];
  assign o_row_idx  = mem_idx_q[rd_ptr_q];
  assign o_row_last = mem_last_q[rd_ptr_q];
`endif

  assign o_row_vld = fifo_vld | fwd;
  assign pop       = o_row_vld & i_row_rdy;
  assign fifo_pop  = pop & ~fwd;
  assign fifo_wr   = ret_ok & ~(fwd & pop);

  assign o_busy = active;
  assign o_done = done_q;
  assign o_err  = err_q;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode and burst control strobes.
  always_comb begin
    state_d     = state_q;
    start_burst = 1'b0;
    zero_start  = 1'b0;
    last_pop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            state_d     = S_FETCH;
            start_burst = 1'b1;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (accept && (issued_q == (len_q - LW'(1)))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && o_row_last) begin
          state_d  = S_IDLE;
          last_pop = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst counters, FIFO pointers and status flags.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      ret_q    <= '0;
      outst_q  <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= last_pop | zero_start;
      err_q  <= (start_burst ? 1'b0 : err_q) | ret_bad;
      if (start_burst) begin
        base_q   <= i_base_addr;
        len_q    <= i_len;
        issued_q <= '0;
        ret_q    <= '0;
        outst_q  <= '0;
        occ_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (accept)   issued_q <= issued_q + LW'(1);
        if (ret_ok)   ret_q    <= ret_q + LW'(1);
        if (fifo_wr)  wr_ptr_q <= wr_ptr_q + PW'(1);
        if (fifo_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        outst_q <= outst_q + CW'(accept) - CW'(ret_ok);
        occ_q   <= occ_q + CW'(fifo_wr) - CW'(fifo_pop);
      end
    end
  end

  // FIFO storage: row data tagged with its burst index and last flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mem_data_q <= '{default: '0};
      mem_idx_q  <= '{default: '0};
      mem_last_q <= '0;
    end else if (fifo_wr) begin
      mem_data_q[wr_ptr_q] <= i_mem_dout;
      mem_idx_q[wr_ptr_q]  <= ret_q;
      mem_last_q[wr_ptr_q] <= ret_last;
    end
  end

endmodule

// File: tb/tb_gsim_row_prefetch.sv
// Bench for gsim_row_prefetch: memory responder with configurable latency,
// burst-level scoreboard compared every cycle, plus directed literal checks.
module tb_gsim_row_prefetch;

  localparam int DEPTH = 4;

  logic         i_clk, i_reset, i_start;
  logic [9:0]   i_base_addr;
  logic [4:0]   i_len;
  logic         o_busy, o_done, o_err, o_mem_rreq;
  logic [9:0]   o_mem_addr;
  logic         i_mem_rrdy;
  logic [255:0] i_mem_dout;
  logic         i_mem_dout_vld;
  logic         o_row_vld;
  logic [255:0] o_row_data;
  logic [4:0]   o_row_idx;
  logic         o_row_last;
  logic         i_row_rdy;

  gsim_row_prefetch #(.DEPTH(DEPTH), .AW(10), .DW(256)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_mem_rreq(o_mem_rreq), .o_mem_addr(o_mem_addr), .i_mem_rrdy(i_mem_rrdy),
    .i_mem_dout(i_mem_dout), .i_mem_dout_vld(i_mem_dout_vld),
    .o_row_vld(o_row_vld), .o_row_data(o_row_data), .o_row_idx(o_row_idx),
    .o_row_last(o_row_last), .i_row_rdy(i_row_rdy)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Row contents are a fixed function of the row address.
  function automatic logic [255:0] row_of(input logic [9:0] a);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = {6'(i), 16'hC3A5, a};
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Memory responder: in-order returns, per-request latency in [lat_min, lat_max].
  typedef struct { logic [9:0] addr; int due; } req_t;
  req_t pend[$];
  int   cyc = 0;
  int   last_due = 0;
  int   n_acc = 0;
  int   lat_min = 1;
  int   lat_max = 1;
  bit   rrdy_rand = 1'b0;

  initial begin
    req_t r;
    i_mem_rrdy     = 1'b1;
    i_mem_dout_vld = 1'b0;
    i_mem_dout     = '0;
    forever begin
      @(negedge i_clk);
      if (o_mem_rreq && i_mem_rrdy) begin
        r.addr = o_mem_addr;
        r.due  = cyc + int'($urandom_range(lat_max, lat_min));
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        pend.push_back(r);
        n_acc++;
      end
      @(posedge i_clk);
      #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        i_mem_dout_vld = 1'b1;
        i_mem_dout     = row_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        i_mem_dout_vld = 1'b0;
      end
      i_mem_rrdy = rrdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Burst-level model: what has been issued, returned and popped so far.
  bit         m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [9:0] m_base = '0;
  int         m_len = 0, m_issued = 0, m_out = 0, m_held = 0, m_popped = 0;
  bit         ret_ok_m, exp_rreq, exp_vld, acc, popped;

  always @(negedge i_clk) begin
    if (i_reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_base = '0;
      m_len = 0; m_issued = 0; m_out = 0; m_held = 0; m_popped = 0;
    end
    ret_ok_m = i_mem_dout_vld && m_busy && (m_out > 0);
    exp_rreq = m_busy && (m_issued < m_len) && ((m_held + m_out) < DEPTH);
    exp_vld  = (m_held > 0);
`ifdef GSIM_ROW_FWD_EN
    if (ret_ok_m && m_held == 0) exp_vld = 1'b1;
`endif
    chk("busy", o_busy, m_busy);
    chk("done", o_done, m_done);
    chk("err", o_err, m_err);
    chk("mem_rreq", o_mem_rreq, exp_rreq);
    if (exp_rreq && o_mem_rreq) chk("mem_addr", o_mem_addr, 10'(m_base + 10'(m_issued)));
    chk("row_vld", o_row_vld, exp_vld);
    if (exp_vld && o_row_vld && m_popped < m_len) begin
      chk("row_idx", o_row_idx, m_popped);
      chk("row_last", o_row_last, (m_popped == m_len - 1));
      chk("row_data", o_row_data, row_of(10'(m_base + 10'(m_popped))));
    end
    if (!i_reset) begin
      acc    = o_mem_rreq && i_mem_rrdy;
      popped = o_row_vld && i_row_rdy;
      m_done = 1'b0;
      if (i_start && !m_busy) begin
        if (i_len != 0) begin
          m_busy = 1'b1; m_err = 1'b0; m_base = i_base_addr; m_len = int'(i_len);
          m_issued = 0; m_out = 0; m_held = 0; m_popped = 0;
        end else begin
          m_done = 1'b1;
        end
      end
      if (acc) begin
        m_issued++;
        m_out++;
      end
      if (i_mem_dout_vld) begin
        if (ret_ok_m) begin
          m_out--;
          m_held++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (popped) begin
        m_held--;
        m_popped++;
        if (m_popped == m_len) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic start(input logic [9:0] b, input logic [4:0] l);
    i_base_addr = b;
    i_len       = l;
    i_start     = 1'b1;
    step(1);
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 1;
    while (!o_done && n < 1000) begin
      step(1);
      n++;
    end
    chk(name, o_done, 1'b1);
  endtask

  int n, a0;

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_base_addr = '0; i_len = '0; i_row_rdy = 1'b0;
    step(2);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_rreq", o_mem_rreq, 1'b0);
    chk("rst_addr", o_mem_addr, 10'd0);
    chk("rst_vld", o_row_vld, 1'b0);
    chk("rst_data", o_row_data, 256'd0);
    chk("rst_idx", o_row_idx, 5'd0);
    chk("rst_last", o_row_last, 1'b0);
    i_reset = 1'b0;
    step(2);

    // Full 17-row problem, latency 1, everything ready.
    i_row_rdy = 1'b1;
    start(10'd17, 5'd17);
    chk("t1_first_rreq", o_mem_rreq, 1'b1);
    chk("t1_first_addr", o_mem_addr, 10'd17);
    chk("t1_busy", o_busy, 1'b1);
    wait_done("t1_done", n);
    chk("t1_done_cycle", n, 20);
    step(1);
    chk("t1_done_pulse", o_done, 1'b0);
    step(2);

    // Credit limit: consumer stalled, latency 2.
    lat_min = 2; lat_max = 2; i_row_rdy = 1'b0;
    a0 = n_acc;
    start(10'd100, 5'd10);
    step(10);
    chk("t2_acc_4", n_acc - a0, 4);
    chk("t2_rreq_low", o_mem_rreq, 1'b0);
    i_row_rdy = 1'b1;
    step(1);
    i_row_rdy = 1'b0;
    chk("t2_rreq_after_pop", o_mem_rreq, 1'b1);
    step(5);
    chk("t2_acc_5", n_acc - a0, 5);
    chk("t2_rreq_low2", o_mem_rreq, 1'b0);
    i_row_rdy = 1'b1;
    wait_done("t2_done", n);
    step(2);

    // Address wrap past 1023.
    start(10'd1020, 5'd8);
    chk("t3_addr_1020", o_mem_addr, 10'd1020);
    step(4);
    chk("t3_wrap_rreq", o_mem_rreq, 1'b1);
    chk("t3_wrap_addr", o_mem_addr, 10'd0);
    wait_done("t3_done", n);
    step(2);

    // Random handshakes and latency 1..3 over 100 bursts.
    rrdy_rand = 1'b1; lat_min = 1; lat_max = 3;
    for (int b = 0; b < 100; b++) begin
      i_row_rdy = 1'($urandom_range(1, 0));
      start(10'($urandom_range(1023, 0)), 5'($urandom_range(17, 1)));
      n = 0;
      while (!o_done && n < 600) begin
        i_row_rdy = 1'($urandom_range(1, 0));
        step(1);
        n++;
      end
      chk("t4_done", o_done, 1'b1);
    end
    chk("t4_err", o_err, 1'b0);
    rrdy_rand = 1'b0;
    i_row_rdy = 1'b0;
    step(8);
    chk("t4_pend_empty", pend.size(), 0);

    // Reset with three reads in flight; their returns arrive afterwards.
    lat_min = 6; lat_max = 6;
    a0 = n_acc;
    start(10'd5, 5'd3);
    step(3);
    chk("t5_acc_3", n_acc - a0, 3);
    i_reset = 1'b1;
    step(1);
    chk("t5_rst_busy", o_busy, 1'b0);
    chk("t5_rst_rreq", o_mem_rreq, 1'b0);
    chk("t5_rst_addr", o_mem_addr, 10'd0);
    chk("t5_rst_vld", o_row_vld, 1'b0);
    chk("t5_rst_data", o_row_data, 256'd0);
    step(1);
    i_reset = 1'b0;
    #1;
    chk("t5_rel_err", o_err, 1'b0);
    step(4);
    chk("t5_stale_err", o_err, 1'b1);
    chk("t5_stale_vld", o_row_vld, 1'b0);
    chk("t5_pend_empty", pend.size(), 0);
    lat_min = 1; lat_max = 1; i_row_rdy = 1'b1;
    start(10'd40, 5'd2);
    chk("t5_err_cleared", o_err, 1'b0);
    wait_done("t5_done", n);
    step(2);

    // Zero-length start.
    a0 = n_acc;
    start(10'd300, 5'd0);
    chk("t6_done", o_done, 1'b1);
    chk("t6_busy", o_busy, 1'b0);
    chk("t6_rreq", o_mem_rreq, 1'b0);
    step(1);
    chk("t6_done_end", o_done, 1'b0);
    chk("t6_no_acc", n_acc - a0, 0);
    step(2);

    // Start while busy is ignored.
    i_row_rdy = 1'b0;
    a0 = n_acc;
    start(10'd200, 5'd4);
    step(1);
    start(10'd0, 5'd9);
    chk("t7_addr_kept", o_mem_addr, 10'd202);
    chk("t7_rreq", o_mem_rreq, 1'b1);
    i_row_rdy = 1'b1;
    wait_done("t7_done", n);
    step(3);
    chk("t7_acc_4", n_acc - a0, 4);
    chk("t7_idle_rreq", o_mem_rreq, 1'b0);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
